// File: rtl/myrv_pkg.sv
// Shared types and constants for the instruction fetch front end.
package myrv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } ifetch_state_t;

  // Buffered instruction: word plus the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
  } inst_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; head is presented from a register array.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wdata       write request and data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   flush             discard all entries
//   rdata             head entry
//   full, empty       occupancy flags
//   count             number of stored entries
module ifetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so push-while-full is legal with pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && full && !pop)) else $error("ifetch_fifo: write while full");
    end
  end
`endif

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word reads,
// buffers in-order responses with their PC and hands them to the decoder.
// Redirects flush all buffered state; in-flight responses are drained and dropped.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (misaligned redirect halts fetch
// and raises sticky fetch_misalign until the next aligned redirect).
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   imem_req_valid/ready/addr            fetch request channel
//   imem_rsp_valid/data                  in-order response, no backpressure
//   inst_valid/ready, inst_data/pc       instruction channel to decoder
//   redirect_valid/pc                    branch/jump restart
//   fetch_misalign                       sticky misaligned-redirect flag (macro only)
module ifetch_unit
  import myrv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = $bits(inst_entry_t);

  ifetch_state_t   state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [CW-1:0]   inflight, inflight_nxt;
  logic            fire;
  logic            rsp_take;
  logic [CW:0]     occupancy;

  logic [CW-1:0]   ififo_count;
  logic            ififo_empty, ififo_full;
  logic [EW-1:0]   ififo_rdata;
  inst_entry_t     ififo_wentry, head;

  logic [XLEN-1:0] pcq_rdata;
  logic [CW-1:0]   pcq_count;
  logic            pcq_empty, pcq_full;
  logic            unused_sig;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_nxt;
`endif

  // Requests in flight plus buffered words may never exceed the buffer size.
  assign occupancy = {1'b0, inflight} + {1'b0, ififo_count};

  // Only responses arriving in RUN belong to the current fetch stream.
  assign rsp_take = (state == RUN) && imem_rsp_valid && !redirect_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      inflight <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= inflight_nxt;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_nxt;
`endif
    end
  end

  // Next-state, request and redirect handling.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    imem_req_valid = 1'b0;
    fire           = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    misalign_nxt   = misalign_q;
`endif

    imem_req_valid = (state == RUN) && !redirect_valid &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));
    fire           = imem_req_valid && imem_req_ready;

    // Every response retires one in-flight request, kept or dropped.
    inflight_nxt = inflight + CW'(fire) - CW'(imem_rsp_valid);
    if (fire) begin
      pc_nxt = pc + XLEN'(4);
    end

    case (state)
      BOOT:    state_nxt = RUN;
      DRAIN:   if (inflight_nxt == '0) state_nxt = RUN;
      default: state_nxt = state;
    endcase

    if (redirect_valid) begin
      pc_nxt    = {redirect_pc[XLEN-1:2], 2'b00};
      state_nxt = (inflight_nxt != '0) ? DRAIN : RUN;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_nxt = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_nxt    = HALT;
        misalign_nxt = 1'b1;
      end
`endif
    end
  end

  // Addresses of issued requests, matched to responses in order.
  ifetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .wdata (pc),
    .pop   (rsp_take),
    .flush (redirect_valid),
    .rdata (pcq_rdata),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  assign ififo_wentry.pc   = pcq_rdata;
  assign ififo_wentry.data = imem_rsp_data;

  // Instruction buffer feeding the decoder.
  ifetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_take),
    .wdata (ififo_wentry),
    .pop   (inst_ready && !redirect_valid),
    .flush (redirect_valid),
    .rdata (ififo_rdata),
    .full  (ififo_full),
    .empty (ififo_empty),
    .count (ififo_count)
  );

  assign head          = ififo_rdata;
  assign inst_valid    = !ififo_empty;
  assign inst_data     = head.data;
  assign inst_pc       = head.pc;
  assign imem_req_addr = pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign fetch_misalign = misalign_q;
  assign unused_sig     = ^{ififo_full, pcq_full, pcq_count, pcq_empty};
`else
  assign unused_sig     = ^{ififo_full, pcq_full, pcq_count, pcq_empty, redirect_pc[1:0]};
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(rsp_take && pcq_empty)) else $error("ifetch_unit: response without request");
    end
  end
`endif

endmodule
